// File: rtl/edid_eeprom_eddc_pkg.sv
// Shared definitions for the EDID EEPROM / E-DDC slave.
//   ddc_state_t      : protocol FSM state encoding
//   EDID_ADDR_DEF    : default EDID slave address
//   SEG_ADDR_DEF     : default E-DDC segment pointer address
//   cnt_width()      : bits needed to hold a count of 0..n
package edid_eeprom_eddc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SEG,
    ST_SEG_ACK,
    ST_WADDR,
    ST_WADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } ddc_state_t;

  localparam logic [6:0] EDID_ADDR_DEF = 7'h50;
  localparam logic [6:0] SEG_ADDR_DEF  = 7'h30;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/edid_eeprom_eddc_filter.sv
// Input conditioner for one DDC line (SCL or SDA).
//   clk, rst_n : system clock, async active-low reset
//   pin        : raw bus level
//   level      : filtered level (idle high)
//   rise/fall  : one-cycle pulses when the filtered level changes
module edid_eeprom_eddc_filter
  import edid_eeprom_eddc_pkg::*;
#(
  parameter int g_glitch_len = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(g_glitch_len);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      // A new level is taken only after g_glitch_len consecutive differing samples.
      if (sync2 != level) begin
        if (cnt == CW'(g_glitch_len - 1)) begin
          level <= sync2;
          cnt   <= '0;
          rise  <= sync2;
          fall  <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/edid_eeprom_eddc.sv
// EDID EEPROM emulator for an HDMI sink DDC bus with E-DDC segment pointer.
//   clk_sys_i, rst_n_i : system clock, async active-low reset
//   scl_b, sda_b       : DDC bus; SCL is only observed, SDA is open-drain
//   hdmi_p5v_notif_i   : +5V present from source (asynchronous)
//   hdmi_hpd_en_o      : hot-plug detect enable
//   host_*             : host byte port into the EDID array (1-cycle read)
//   host_hpd_pulse_i   : start/restart the HPD low pulse
//   busy_o             : I2C transfer in progress (address ACK to STOP)
module edid_eeprom_eddc
  import edid_eeprom_eddc_pkg::*;
#(
  parameter int         g_size           = 256,
  parameter logic [6:0] g_address        = EDID_ADDR_DEF,
  parameter logic [6:0] g_seg_address    = SEG_ADDR_DEF,
  parameter bit         g_i2c_writable   = 1'b0,
  parameter int         g_glitch_len     = 3,
  parameter int         g_hpd_low_cycles = 6250000
) (
  input  logic       clk_sys_i,
  input  logic       rst_n_i,
  inout  wire        scl_b,
  inout  wire        sda_b,
  input  logic       hdmi_p5v_notif_i,
  output logic       hdmi_hpd_en_o,
  input  logic [8:0] host_addr_i,
  input  logic [7:0] host_data_i,
  input  logic       host_wr_i,
  output logic [7:0] host_data_o,
  input  logic       host_hpd_pulse_i,
  output logic       busy_o
);

  localparam int AW = $clog2(g_size);
  localparam int HW = cnt_width(g_hpd_low_cycles);

  logic [7:0] mem [0:g_size-1];

  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start_cond, stop_cond, rx_state, byte_done, in_range, i2c_we;
  logic [8:0] full_addr;
  logic [7:0] ram_q, rd_byte;
  logic       ram_ok;

  ddc_state_t state;
  logic [3:0] bit_cnt;
  logic [7:0] sh, tx, offset;
  logic       seg, rw, is_seg, sda_oe;

  logic          p5v_s1, p5v_s2;
  logic [HW-1:0] hpd_cnt;
  logic          unused_bits;

  edid_eeprom_eddc_filter #(.g_glitch_len(g_glitch_len)) u_scl_filt (
    .clk(clk_sys_i), .rst_n(rst_n_i), .pin(scl_b),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  edid_eeprom_eddc_filter #(.g_glitch_len(g_glitch_len)) u_sda_filt (
    .clk(clk_sys_i), .rst_n(rst_n_i), .pin(sda_b),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  assign sda_b       = sda_oe ? 1'b0 : 1'bz;
  assign unused_bits = ^host_addr_i;

  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;
  assign rx_state   = state inside {ST_ADDR, ST_SEG, ST_WADDR, ST_WDATA};
  assign byte_done  = scl_fall & (bit_cnt == 4'd8);
  assign full_addr  = {seg, offset};
  assign in_range   = {1'b0, full_addr} < 10'(g_size);
  assign rd_byte    = ram_ok ? ram_q : 8'hFF;

  // Host write has priority; a colliding I2C byte is simply lost.
  assign i2c_we = g_i2c_writable && (state == ST_WDATA) && byte_done && in_range
                  && !start_cond && !stop_cond && !host_wr_i;

  // Array: shared write port, one read port per side. Contents are never reset.
  always_ff @(posedge clk_sys_i) begin
    if (host_wr_i)
      mem[host_addr_i[AW-1:0]] <= host_data_i;
    else if (i2c_we)
      mem[full_addr[AW-1:0]] <= sh;
    ram_q  <= mem[full_addr[AW-1:0]];
    ram_ok <= in_range;
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) host_data_o <= 8'h00;
    else          host_data_o <= mem[host_addr_i[AW-1:0]];
  end

  // Protocol FSM; START/STOP override every state.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sh      <= '0;
      tx      <= '0;
      offset  <= '0;
      seg     <= 1'b0;
      rw      <= 1'b0;
      is_seg  <= 1'b0;
      sda_oe  <= 1'b0;
      busy_o  <= 1'b0;
    end else if (start_cond) begin
      state   <= ST_ADDR;
      bit_cnt <= '0;
      sda_oe  <= 1'b0;
    end else if (stop_cond) begin
      state  <= ST_IDLE;
      seg    <= 1'b0;
      busy_o <= 1'b0;
      sda_oe <= 1'b0;
    end else begin
      if (scl_rise && rx_state) begin
        sh      <= {sh[6:0], sda_lvl};
        bit_cnt <= bit_cnt + 4'd1;
      end
      case (state)
        ST_ADDR: if (byte_done) begin
          bit_cnt <= '0;
          if (sh[7:1] == g_address) begin
            state <= ST_ADDR_ACK; sda_oe <= 1'b1; busy_o <= 1'b1;
            rw <= sh[0]; is_seg <= 1'b0;
          end else if (sh == {g_seg_address, 1'b0}) begin
            state <= ST_ADDR_ACK; sda_oe <= 1'b1; busy_o <= 1'b1;
            rw <= 1'b0; is_seg <= 1'b1;
          end else begin
            state <= ST_IGNORE;
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (is_seg) begin
            state <= ST_SEG; sda_oe <= 1'b0;
          end else if (rw) begin
            // First read byte goes straight onto the bus at the ACK's SCL fall.
            state <= ST_RDATA; tx <= rd_byte; sda_oe <= ~rd_byte[7];
          end else begin
            state <= ST_WADDR; sda_oe <= 1'b0;
          end
        end
        ST_SEG: if (byte_done) begin
          bit_cnt <= '0;
          seg     <= (g_size > 256) ? sh[0] : 1'b0;
          state   <= ST_SEG_ACK; sda_oe <= 1'b1;
        end
        ST_SEG_ACK: if (scl_fall) begin
          state <= ST_IGNORE; sda_oe <= 1'b0;
        end
        ST_WADDR: if (byte_done) begin
          bit_cnt <= '0; offset <= sh;
          state   <= ST_WADDR_ACK; sda_oe <= 1'b1;
        end
        ST_WADDR_ACK, ST_WDATA_ACK: if (scl_fall) begin
          state <= ST_WDATA; sda_oe <= 1'b0;
        end
        ST_WDATA: if (byte_done) begin
          bit_cnt <= '0; offset <= offset + 8'd1;
          state   <= ST_WDATA_ACK; sda_oe <= 1'b1;
        end
        ST_RDATA: if (scl_fall) begin
          if (bit_cnt == 4'd7) begin
            state <= ST_RDATA_ACK; bit_cnt <= '0; sda_oe <= 1'b0;
          end else begin
            tx <= {tx[6:0], 1'b0}; sda_oe <= ~tx[6]; bit_cnt <= bit_cnt + 4'd1;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_lvl) state  <= ST_IGNORE;
            else         offset <= offset + 8'd1;
          end else if (scl_fall) begin
            // Offset moved at the ACK rise; ram_q has settled by this fall.
            state <= ST_RDATA; tx <= rd_byte; sda_oe <= ~rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  // HPD: low while the pulse counter runs, and whenever +5V is absent.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p5v_s1  <= 1'b0;
      p5v_s2  <= 1'b0;
      hpd_cnt <= '0;
    end else begin
      p5v_s1 <= hdmi_p5v_notif_i;
      p5v_s2 <= p5v_s1;
      if (host_hpd_pulse_i)  hpd_cnt <= HW'(g_hpd_low_cycles);
      else if (hpd_cnt != 0) hpd_cnt <= hpd_cnt - 1'b1;
    end
  end

  assign hdmi_hpd_en_o = p5v_s2 & (hpd_cnt == '0);

endmodule
